// File: rtl/hamming_stream_encoder.sv
// Two-stage pipelined systematic Hamming encoder (optional SECDED bit) with a
// valid/ready stream interface and a delivered-codeword counter.
module hamming_stream_encoder #(
  parameter int DATA_W = 4,
  parameter int SECDED = 0,
  localparam int R = (DATA_W <= 1)  ? 2 :
                     (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 : 6,
  localparam int CW_W = DATA_W + R + SECDED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [CW_W-1:0]   data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       word_cnt_o
);

  // Bit j*DATA_W+i is set when data bit i sits at a codeword position with bit j set.
  function automatic logic [R*DATA_W-1:0] calc_masks();
    logic [R*DATA_W-1:0] m;
    int pos;
    m   = '0;
    pos = 2;
    for (int i = 0; i < DATA_W; i++) begin
      pos = pos + 1;
      if ((pos & (pos - 1)) == 0) pos = pos + 1;
      for (int j = 0; j < R; j++)
        if (((pos >> j) & 1) != 0) m[j*DATA_W + i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [R*DATA_W-1:0] MASKS = calc_masks();

  logic [DATA_W-1:0] s1_data;
  logic [R-1:0]      s1_par;
  logic              v1;
  logic              v2;
  logic [R-1:0]      par;
  logic [CW_W-1:0]   cw_next;
  logic              load2;
  logic              in_xfer;

  always_comb begin
    par = '0;
    for (int j = 0; j < R; j++)
      par[j] = ^(data_i & MASKS[j*DATA_W +: DATA_W]);
  end

  always_comb begin
    cw_next = '0;
    cw_next[DATA_W+R-1:0] = {s1_par, s1_data};
    if (SECDED != 0) cw_next[CW_W-1] = ^{s1_par, s1_data};
  end

  assign load2   = !v2 || ready_i;
  assign ready_o = !v1 || load2;
  assign in_xfer = valid_i && ready_o;
  assign valid_o = v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_par  <= '0;
      v1      <= 1'b0;
    end else if (in_xfer) begin
      s1_data <= data_i;
      s1_par  <= par;
      v1      <= 1'b1;
    end else if (load2) begin
      v1      <= 1'b0;
    end
  end

  // Stage 2 only takes new data when stage 1 actually holds a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o <= '0;
      v2     <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) data_o <= cw_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_o <= '0;
    end else if (v2 && ready_i) begin
      word_cnt_o <= word_cnt_o + 32'd1;
    end
  end

endmodule
